vga_timing_ctrl: RTL and testbench
==================================

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-002 Parameter H_BP, 48, horizontal back porch in pixels.
REQ-003 Parameter H_ACT, 640, horizontal active pixels.
REQ-004 Parameter H_FP, 16, horizontal front porch in pixels.
REQ-005 Parameters V_SYNC, V_BP, V_ACT, V_FP, defaults 2, 33, 480, 10, the same four phases in lines.
REQ-006 Parameter CLK_DIV, 4, number of clk cycles per pixel tick (100 MHz clk gives a 25 MHz pixel rate).
REQ-007 clk  input  1  system clock; all logic on the rising edge.
REQ-008 rst  input  1  reset, synchronous and active-high.
REQ-009 en  input  1  run enable; low freezes all timing state.
REQ-010 hCount  output  32  horizontal pixel count, 0..H_TOTAL-1, where H_TOTAL is the sum of the four horizontal phases.
REQ-011 vCount  output  32  vertical line count, 0..V_TOTAL-1, where V_TOTAL is the sum of the four vertical phases.
REQ-012 HS, VS  output  1 each  sync pulses, active-high.
REQ-013 video_on  output  1  high when hCount and vCount are both in their active phase.
REQ-014 pix_x, pix_y  output  10 each  active-area coordinates; 0 outside the active area.
REQ-015 pix_tick  output  1  one-clk strobe marking each pixel advance.
REQ-016 line_start, frame_start  output  1 each  one-clk strobes.

Function
REQ-017 The pixel tick SHALL assert for one clk every CLK_DIV clk cycles while en=1.
- The divider SHALL hold its value while en=0.
REQ-018 Counting SHALL occur only on a pixel tick:
- hCount increments by 1; H_TOTAL-1 wraps to 0.
- vCount increments only on the tick where hCount wraps; V_TOTAL-1 wraps to 0.
REQ-019 The horizontal FSM SHALL have the states H_SYNC, H_BPORCH, H_ACTIVE and H_FPORCH.
- Order: H_SYNC -> H_BPORCH -> H_ACTIVE -> H_FPORCH -> H_SYNC.
- Each transition occurs on the tick where hCount enters the first count of the next phase.
REQ-020 The vertical FSM SHALL have the states V_SYNC, V_BPORCH, V_ACTIVE and V_FPORCH and sequence identically, advancing only on hCount wrap.
REQ-021 All outputs SHALL be registered and mutually consistent in the same cycle.
- HS=1 exactly when hCount is in 0..H_SYNC-1.
- VS=1 exactly when vCount is in 0..V_SYNC-1.
REQ-022 video_on SHALL be 1 exactly when hCount is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT-1] and vCount is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT-1].
- pix_x = hCount-(H_SYNC+H_BP) when video_on=1, else 0.
- pix_y = vCount-(V_SYNC+V_BP) when video_on=1, else 0.
REQ-023 line_start SHALL pulse for one clk in the cycle hCount becomes 0 by wrap.
- frame_start SHALL pulse in the cycle both counters become 0 by wrap.
- At end of frame, line_start and frame_start SHALL assert together.
REQ-024 pix_tick SHALL be high in the same cycle the counters show their new value.
REQ-025 en=0 SHALL hold every counter, FSM state and level output, and SHALL force all strobes to 0.
REQ-026 Counter arithmetic SHALL be unsigned 32-bit; pix_x and pix_y SHALL be the low 10 bits of their differences.

Reset
REQ-027 On rst=1 at a clk edge, the following SHALL take effect on that edge, overriding en:
- hCount=0, vCount=0, divider=0.
- Horizontal FSM in H_SYNC, vertical FSM in V_SYNC.
- HS=1, VS=1, video_on=0, pix_x=0, pix_y=0.
- pix_tick=0, line_start=0, frame_start=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame.
- frame_start SHALL NOT pulse for the reset itself.
- The first pix_tick after rst falls (with en=1) SHALL occur CLK_DIV clk cycles later.

Configuration
REQ-029 With VGA_TC_FRAME_CNT_EN defined, the block SHALL add an output frame_cnt (16 bits).
- frame_cnt increments on every frame_start and wraps at 65535 to 0.
- Reset value is 0.
REQ-030 Without VGA_TC_FRAME_CNT_EN, neither the frame_cnt port nor its register SHALL exist.

Structure
REQ-031 Package vga_timing_pkg SHALL hold:
- the horizontal and vertical phase state typedefs;
- the default 640x480@60 timing constants used as parameter defaults.
REQ-032 The pixel-tick divider SHALL be a sub-module, vga_tick_gen, with ports clk, rst, en and tick.

Verification
REQ-033 Release rst with en=1 and defaults -> first pix_tick on clk 4 after release; hCount=1 on that cycle; HS=1 until hCount=96, where HS=0.
REQ-034 Run to hCount=144, vCount=35 -> video_on=1, pix_x=0, pix_y=0; at hCount=783 pix_x=639; at hCount=784 video_on=0 and pix_x=0.
REQ-035 Run to hCount=799, vCount=524, then one tick -> hCount=0, vCount=0, line_start=1, frame_start=1, VS=1, HS=1 in the same cycle.
REQ-036 Drive en=0 at hCount=300 for 50 clk -> hCount stays 300, all strobes 0; after en=1, hCount=301 after 4 clk.
REQ-037 Assert rst at hCount=500, vCount=200 -> next cycle all outputs at reset values; no frame_start pulse.
REQ-038 With VGA_TC_FRAME_CNT_EN defined, run 3 full frames (3x800x525 ticks) -> frame_cnt=3.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg -- shared types and default 640x480@60 timing constants
// for the VGA timing controller.
package vga_timing_pkg;

    // Horizontal phase sequence, in the order the beam traverses a line.
    typedef enum logic [1:0] {
        H_SYNC,
        H_BPORCH,
        H_ACTIVE,
        H_FPORCH
    } hPhase_t;

    // Vertical phase sequence, in the order the beam traverses a frame.
    typedef enum logic [1:0] {
        V_SYNC,
        V_BPORCH,
        V_ACTIVE,
        V_FPORCH
    } vPhase_t;

    // 640x480@60 with a 25 MHz pixel clock derived from 100 MHz.
    localparam int unsigned DEF_H_SYNC  = 96;
    localparam int unsigned DEF_H_BP    = 48;
    localparam int unsigned DEF_H_ACT   = 640;
    localparam int unsigned DEF_H_FP    = 16;
    localparam int unsigned DEF_V_SYNC  = 2;
    localparam int unsigned DEF_V_BP    = 33;
    localparam int unsigned DEF_V_ACT   = 480;
    localparam int unsigned DEF_V_FP    = 10;
    localparam int unsigned DEF_CLK_DIV = 4;

    // Length of one full line or frame from its four phase widths.
    function automatic int unsigned phaseTotal(
        input int unsigned syncW,
        input int unsigned bpW,
        input int unsigned actW,
        input int unsigned fpW
    );
        return syncW + bpW + actW + fpW;
    endfunction

endpackage

// File: rtl/vga_tick_gen.sv
// vga_tick_gen -- pixel-rate advance strobe, one clk in every CLK_DIV
// enabled clk cycles. The divider freezes while en is low.
module vga_tick_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
)(
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] divCount;

    // The strobe is decoded from the divider register so the top can
    // update its counters and register pix_tick on the same edge.
    assign tick = en && (divCount == LAST);

    // Divider: count enabled cycles, wrap after CLK_DIV of them.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            divCount <= '0;
        end else if (en) begin
            divCount <= (divCount == LAST) ? '0 : divCount + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl -- VGA horizontal/vertical timing generator with
// registered sync, blanking, coordinate and strobe outputs.
// Optional feature: define VGA_TC_FRAME_CNT_EN to add the 16-bit frame_cnt
// output counting frame_start pulses.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_SYNC  = DEF_H_SYNC,
    parameter int unsigned H_BP    = DEF_H_BP,
    parameter int unsigned H_ACT   = DEF_H_ACT,
    parameter int unsigned H_FP    = DEF_H_FP,
    parameter int unsigned V_SYNC  = DEF_V_SYNC,
    parameter int unsigned V_BP    = DEF_V_BP,
    parameter int unsigned V_ACT   = DEF_V_ACT,
    parameter int unsigned V_FP    = DEF_V_FP,
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] hCount,
    output logic [31:0] vCount,
    output logic        HS,
    output logic        VS,
    output logic        video_on,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_tick,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_TC_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    // The H_SYNC / V_SYNC parameters shadow the same-named phase literals,
    // so those two states are referenced through the package scope.
    localparam int unsigned H_TOTAL     = phaseTotal(H_SYNC, H_BP, H_ACT, H_FP);
    localparam int unsigned V_TOTAL     = phaseTotal(V_SYNC, V_BP, V_ACT, V_FP);
    localparam int unsigned H_ACT_START = H_SYNC + H_BP;
    localparam int unsigned H_FP_START  = H_ACT_START + H_ACT;
    localparam int unsigned V_ACT_START = V_SYNC + V_BP;
    localparam int unsigned V_FP_START  = V_ACT_START + V_ACT;

    logic        tick;
    logic        hWrap;
    logic        vWrap;
    logic [31:0] hNext;
    logic [31:0] vNext;
    logic        actNext;
    hPhase_t     hState;
    vPhase_t     vState;

    vga_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    // Next counter values and active-area decode for the coming tick.
    // NOTE: every signal here is assigned on every pass, so no latch can
    // be inferred.
    always_comb begin
        hWrap   = (hCount == H_TOTAL - 1);
        vWrap   = (vCount == V_TOTAL - 1);
        hNext   = hWrap ? '0 : hCount + 32'd1;
        vNext   = hWrap ? (vWrap ? '0 : vCount + 32'd1) : vCount;
        actNext = (hNext >= H_ACT_START) && (hNext < H_FP_START) &&
                  (vNext >= V_ACT_START) && (vNext < V_FP_START);
    end

    // Horizontal phase FSM; HS is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            hState <= vga_timing_pkg::H_SYNC;
            HS     <= 1'b1;
        end else if (tick) begin
            case (hState)
                vga_timing_pkg::H_SYNC:
                    if (hNext == H_SYNC) begin
                        hState <= H_BPORCH;
                        HS     <= 1'b0;
                    end
                H_BPORCH:
                    if (hNext == H_ACT_START) hState <= H_ACTIVE;
                H_ACTIVE:
                    if (hNext == H_FP_START) hState <= H_FPORCH;
                H_FPORCH:
                    if (hNext == '0) begin
                        hState <= vga_timing_pkg::H_SYNC;
                        HS     <= 1'b1;
                    end
                default: begin
                    hState <= vga_timing_pkg::H_SYNC;
                    HS     <= 1'b1;
                end
            endcase
        end
    end

    // Vertical phase FSM; advances only on the tick that wraps hCount.
    always_ff @(posedge clk) begin
        if (rst) begin
            vState <= vga_timing_pkg::V_SYNC;
            VS     <= 1'b1;
        end else if (tick && hWrap) begin
            case (vState)
                vga_timing_pkg::V_SYNC:
                    if (vNext == V_SYNC) begin
                        vState <= V_BPORCH;
                        VS     <= 1'b0;
                    end
                V_BPORCH:
                    if (vNext == V_ACT_START) vState <= V_ACTIVE;
                V_ACTIVE:
                    if (vNext == V_FP_START) vState <= V_FPORCH;
                V_FPORCH:
                    if (vNext == '0) begin
                        vState <= vga_timing_pkg::V_SYNC;
                        VS     <= 1'b1;
                    end
                default: begin
                    vState <= vga_timing_pkg::V_SYNC;
                    VS     <= 1'b1;
                end
            endcase
        end
    end

    // Counters, active-area outputs and strobes; strobes derive from the
    // enable-gated tick, so they drop to 0 whenever en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            hCount      <= '0;
            vCount      <= '0;
            video_on    <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_tick    <= tick;
            line_start  <= tick && hWrap;
            frame_start <= tick && hWrap && vWrap;
            if (tick) begin
                hCount   <= hNext;
                vCount   <= vNext;
                video_on <= actNext;
                pix_x    <= actNext ? 10'(hNext - H_ACT_START) : '0;
                pix_y    <= actNext ? 10'(vNext - V_ACT_START) : '0;
            end
        end
    end

`ifdef VGA_TC_FRAME_CNT_EN
    // Frame counter, stepping with every frame_start and wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (tick && hWrap && vWrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl -- self-checking bench for vga_timing_ctrl using a
// reduced timing set so whole frames fit in a short run. The reference
// derives the expected beam position from the number of enabled cycles.
module tb_vga_timing_ctrl;

    localparam int unsigned H_SYNC  = 8;
    localparam int unsigned H_BP    = 4;
    localparam int unsigned H_ACT   = 16;
    localparam int unsigned H_FP    = 4;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BP    = 3;
    localparam int unsigned V_ACT   = 6;
    localparam int unsigned V_FP    = 2;
    localparam int unsigned CLK_DIV = 4;

    localparam int unsigned H_TOTAL     = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int unsigned V_TOTAL     = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int unsigned H_ACT_START = H_SYNC + H_BP;
    localparam int unsigned V_ACT_START = V_SYNC + V_BP;
    localparam int unsigned FRAME_CLKS  = H_TOTAL * V_TOTAL * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [31:0] hCount;
    logic [31:0] vCount;
    logic        HS;
    logic        VS;
    logic        video_on;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_tick;
    logic        line_start;
    logic        frame_start;
`ifdef VGA_TC_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    vga_timing_ctrl #(
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .H_ACT   (H_ACT),
        .H_FP    (H_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP),
        .V_ACT   (V_ACT),
        .V_FP    (V_FP),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .hCount      (hCount),
        .vCount      (vCount),
        .HS          (HS),
        .VS          (VS),
        .video_on    (video_on),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_tick    (pix_tick),
        .line_start  (line_start),
        .frame_start (frame_start)
`ifdef VGA_TC_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference state: enabled cycles since reset and what they imply.
    int unsigned enCyc   = 0;
    int unsigned mH      = 0;
    int unsigned mV      = 0;
    logic        expTick  = 1'b0;
    logic        expLine  = 1'b0;
    logic        expFrame = 1'b0;
    logic [15:0] mFrames  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkModel();
        logic mAct;
        mAct = (mH >= H_ACT_START) && (mH < H_ACT_START + H_ACT) &&
               (mV >= V_ACT_START) && (mV < V_ACT_START + V_ACT);
        chk("hCount", hCount, mH);
        chk("vCount", vCount, mV);
        chk("HS", {31'd0, HS}, {31'd0, mH < H_SYNC});
        chk("VS", {31'd0, VS}, {31'd0, mV < V_SYNC});
        chk("video_on", {31'd0, video_on}, {31'd0, mAct});
        chk("pix_x", {22'd0, pix_x}, mAct ? (mH - H_ACT_START) : 32'd0);
        chk("pix_y", {22'd0, pix_y}, mAct ? (mV - V_ACT_START) : 32'd0);
        chk("pix_tick", {31'd0, pix_tick}, {31'd0, expTick});
        chk("line_start", {31'd0, line_start}, {31'd0, expLine});
        chk("frame_start", {31'd0, frame_start}, {31'd0, expFrame});
`ifdef VGA_TC_FRAME_CNT_EN
        chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, mFrames});
`endif
    endtask

    // One clk edge with the given inputs, model update, then full check.
    task automatic step(input logic r, input logic e);
        int unsigned n;
        rst = r;
        en  = e;
        @(posedge clk);
        if (r) begin
            enCyc   = 0;
            mFrames = '0;
            expTick = 1'b0;
        end else if (e) begin
            enCyc++;
            expTick = (enCyc % CLK_DIV) == 0;
        end else begin
            expTick = 1'b0;
        end
        n        = enCyc / CLK_DIV;
        mH       = n % H_TOTAL;
        mV       = (n / H_TOTAL) % V_TOTAL;
        expLine  = expTick && (mH == 0);
        expFrame = expLine && (mV == 0);
        if (expFrame) mFrames++;
        #1;
        checkModel();
    endtask

    // Run enabled until the tick that lands on (h, v), within a bound.
    task automatic runTo(input int unsigned h, input int unsigned v);
        int unsigned budget;
        budget = 2 * FRAME_CLKS;
        do begin
            step(1'b0, 1'b1);
            budget--;
        end while (!(expTick && mH == h && mV == v) && budget != 0);
        if (!(expTick && mH == h && mV == v)) begin
            compared++;
            mismatched++;
            $error("FAIL runTo_timeout: position (%0d,%0d) not reached", h, v);
        end
    endtask

    initial begin
        // Reset state.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("rst_HS", {31'd0, HS}, 32'd1);
        chk("rst_video_on", {31'd0, video_on}, 32'd0);

        // First tick CLK_DIV clks after release, with hCount already 1.
        for (int i = 1; i <= int'(CLK_DIV); i++) begin
            step(1'b0, 1'b1);
            if (i == int'(CLK_DIV)) begin
                chk("first_tick", {31'd0, pix_tick}, 32'd1);
                chk("first_tick_hCount", hCount, 32'd1);
            end else begin
                chk("no_early_tick", {31'd0, pix_tick}, 32'd0);
            end
        end

        // HS boundary.
        runTo(H_SYNC - 1, 0);
        chk("HS_last_sync", {31'd0, HS}, 32'd1);
        runTo(H_SYNC, 0);
        chk("HS_after_sync", {31'd0, HS}, 32'd0);

        // Active-area edges.
        runTo(H_ACT_START, V_ACT_START);
        chk("act_first_video", {31'd0, video_on}, 32'd1);
        chk("act_first_pix_x", {22'd0, pix_x}, 32'd0);
        chk("act_first_pix_y", {22'd0, pix_y}, 32'd0);
        runTo(H_ACT_START + H_ACT - 1, V_ACT_START);
        chk("act_last_pix_x", {22'd0, pix_x}, H_ACT - 1);
        runTo(H_ACT_START + H_ACT, V_ACT_START);
        chk("fp_video_off", {31'd0, video_on}, 32'd0);
        chk("fp_pix_x", {22'd0, pix_x}, 32'd0);

        // End-of-frame wrap.
        runTo(H_TOTAL - 1, V_TOTAL - 1);
        runTo(0, 0);
        chk("eof_line_start", {31'd0, line_start}, 32'd1);
        chk("eof_frame_start", {31'd0, frame_start}, 32'd1);
        chk("eof_VS", {31'd0, VS}, 32'd1);
        chk("eof_HS", {31'd0, HS}, 32'd1);

        // Enable hold.
        runTo(10, 1);
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0);
            chk("hold_hCount", hCount, 32'd10);
            chk("hold_pix_tick", {31'd0, pix_tick}, 32'd0);
        end
        for (int i = 1; i <= int'(CLK_DIV); i++) begin
            step(1'b0, 1'b1);
            chk("resume_hCount", hCount, (i == int'(CLK_DIV)) ? 32'd11 : 32'd10);
        end

        // Mid-frame reset.
        runTo(20, 7);
        step(1'b1, 1'b1);
        chk("midrst_hCount", hCount, 32'd0);
        chk("midrst_vCount", vCount, 32'd0);
        chk("midrst_frame_start", {31'd0, frame_start}, 32'd0);
        step(1'b1, 1'b0);

        // Three full frames from a fresh reset.
        for (int f = 0; f < 3; f++) runTo(0, 0);
`ifdef VGA_TC_FRAME_CNT_EN
        chk("frame_cnt_3", {16'd0, frame_cnt}, 32'd3);
`endif

        // Randomized enable and occasional reset.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 499) == 0, $urandom_range(0, 7) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
